// File: rtl/alu_core.sv
// Registered ALU: one-cycle result for most ops, W-cycle shift-add multiply.
// Optional multiplier enabled by defining ALU_MULT_EN; otherwise OP=2 yields zero in one cycle.
module alu_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ACT,
  input  logic [3:0]            OP,
  input  logic [1:0]            MOVI,
  input  logic [DATA_WIDTH-1:0] REG_A,
  input  logic [DATA_WIDTH-1:0] REG_B,
  input  logic [DATA_WIDTH-1:0] MEM,
  input  logic [DATA_WIDTH-1:0] IMM,
  output logic                  ALU_RDY,
  output logic [DATA_WIDTH-1:0] EX_ALU,
  output logic                  EX_ALU_VLD
);

  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_ROR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

`ifdef ALU_MULT_EN
  localparam int CNT_W = $clog2(W) + 1;
  typedef enum logic [0:0] {IDLE, MULT_BUSY} state_t;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [0:0] {IDLE} state_t;
`endif

  state_t       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         pend_q, pend_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] ex_q, ex_d;
  logic         vld_q, vld_d;

  logic         accept;
  logic [W-1:0] opb;
  logic [W-1:0] alu_res;

  assign accept = ACT && rdy_q;

  always_comb begin
    opb = '0;
    case (MOVI)
      2'd0:    opb = REG_B;
      2'd1:    opb = MEM;
      2'd2:    opb = IMM;
      default: opb = '0;
    endcase
  end

  // Single-cycle datapath on the captured operands; MULT is produced by the FSM instead.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_MULT: alu_res = '0;
      OP_SHR:  alu_res = {1'b0, a_q[W-1:1]};
      OP_SHL:  alu_res = {a_q[W-2:0], 1'b0};
      OP_ROR:  alu_res = {a_q[0], a_q[W-1:1]};
      OP_ROL:  alu_res = {a_q[W-2:0], a_q[W-1]};
      OP_NOT:  alu_res = ~a_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NAND: alu_res = ~(a_q & b_q);
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      OP_INC:  alu_res = a_q + 1'b1;
      OP_DEC:  alu_res = a_q - 1'b1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    pend_d  = 1'b0;
    rdy_d   = 1'b1;
    ex_d    = ex_q;
    vld_d   = 1'b0;
`ifdef ALU_MULT_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`endif

    if (pend_q) begin
      ex_d  = alu_res;
      vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = OP;
          a_d  = REG_A;
          b_d  = opb;
`ifdef ALU_MULT_EN
          if (OP == OP_MULT) begin
            state_d = MULT_BUSY;
            rdy_d   = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            pend_d = 1'b1;
          end
`else
          pend_d = 1'b1;
`endif
        end
      end
`ifdef ALU_MULT_EN
      MULT_BUSY: begin
        // a_q walks left as the multiplicand, b_q walks right exposing the next multiplier bit.
        rdy_d = 1'b0;
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          ex_d    = acc_d;
          vld_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ex_q    <= '0;
      vld_q   <= 1'b0;
`ifdef ALU_MULT_EN
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      ex_q    <= ex_d;
      vld_q   <= vld_d;
`ifdef ALU_MULT_EN
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ALU_RDY    = rdy_q;
  assign EX_ALU     = ex_q;
  assign EX_ALU_VLD = vld_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core (W=8); multiplier checks follow the ALU_MULT_EN build setting.
module tb_alu_core;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ACT;
  logic [3:0] OP;
  logic [1:0] MOVI;
  logic [7:0] REG_A, REG_B, MEM, IMM;
  logic       ALU_RDY;
  logic [7:0] EX_ALU;
  logic       EX_ALU_VLD;

  int tests = 0;
  int fails = 0;

  alu_core #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ACT        (ACT),
    .OP         (OP),
    .MOVI       (MOVI),
    .REG_A      (REG_A),
    .REG_B      (REG_B),
    .MEM        (MEM),
    .IMM        (IMM),
    .ALU_RDY    (ALU_RDY),
    .EX_ALU     (EX_ALU),
    .EX_ALU_VLD (EX_ALU_VLD)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] movi, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] mem, input logic [7:0] imm);
    ACT = 1'b1; OP = op; MOVI = movi; REG_A = a; REG_B = b; MEM = mem; IMM = imm;
  endtask

  // Single request: accept on one edge, expect the result exactly one edge later.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [1:0] movi,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    drive(op, movi, a, b, ~b, 8'h5A);
    tick();
    ACT = 1'b0;
    REG_A = 8'hC3; REG_B = 8'h3C;
    chk({tag, "_early"}, {7'd0, EX_ALU_VLD}, 8'd0);
    chk({tag, "_rdy"}, {7'd0, ALU_RDY}, 8'd1);
    tick();
    chk({tag, "_vld"}, {7'd0, EX_ALU_VLD}, 8'd1);
    chk(tag, EX_ALU, exp);
  endtask

  initial begin
    RST = 1'b0; ACT = 1'b0; OP = '0; MOVI = '0;
    REG_A = '0; REG_B = '0; MEM = '0; IMM = '0;

    tick(); tick();
    chk("rst_ex", EX_ALU, 8'h00);
    chk("rst_vld", {7'd0, EX_ALU_VLD}, 8'd0);
    chk("rst_rdy", {7'd0, ALU_RDY}, 8'd0);
    RST = 1'b1;
    tick();
    chk("rel_rdy", {7'd0, ALU_RDY}, 8'd1);
    chk("rel_vld", {7'd0, EX_ALU_VLD}, 8'd0);

    run_op("add_wrap", 4'd0, 2'd0, 8'hFF, 8'h01, 8'h00);
    tick();
    chk("add_pulse_end", {7'd0, EX_ALU_VLD}, 8'd0);

    // SUB via MEM then XOR via IMM on consecutive edges.
    drive(4'd1, 2'd1, 8'h03, 8'h77, 8'h05, 8'h55);
    tick();
    drive(4'd10, 2'd2, 8'h0F, 8'h77, 8'h33, 8'hF0);
    tick();
    ACT = 1'b0;
    chk("sub_vld", {7'd0, EX_ALU_VLD}, 8'd1);
    chk("sub_mem", EX_ALU, 8'hFE);
    tick();
    chk("xor_vld", {7'd0, EX_ALU_VLD}, 8'd1);
    chk("xor_imm", EX_ALU, 8'hFF);
    tick();
    chk("hold_vld", {7'd0, EX_ALU_VLD}, 8'd0);
    chk("hold_ex", EX_ALU, 8'hFF);

    run_op("rol", 4'd6, 2'd0, 8'h81, 8'h00, 8'h03);
    run_op("shr", 4'd3, 2'd0, 8'h81, 8'h00, 8'h40);
    run_op("dec", 4'd15, 2'd0, 8'h00, 8'h00, 8'hFF);
    run_op("and_zero", 4'd8, 2'd3, 8'hFF, 8'hFF, 8'h00);
    run_op("shl", 4'd4, 2'd0, 8'h81, 8'h00, 8'h02);
    run_op("ror", 4'd5, 2'd0, 8'h81, 8'h00, 8'hC0);
    run_op("not", 4'd7, 2'd0, 8'h0F, 8'h00, 8'hF0);
    run_op("or", 4'd9, 2'd0, 8'h0C, 8'h30, 8'h3C);
    run_op("nand", 4'd11, 2'd0, 8'hF0, 8'h3C, 8'hCF);
    run_op("nor", 4'd12, 2'd0, 8'h0C, 8'h30, 8'hC3);
    run_op("xnor", 4'd13, 2'd0, 8'hF0, 8'h3C, 8'h33);
    run_op("inc", 4'd14, 2'd0, 8'hFF, 8'h00, 8'h00);
    run_op("add_imm", 4'd0, 2'd2, 8'h10, 8'h00, 8'h6A);

    // Reset with a single-cycle op in flight: its result must never appear.
    drive(4'd0, 2'd0, 8'h11, 8'h22, 8'h00, 8'h00);
    tick();
    ACT = 1'b0;
    RST = 1'b0;
    tick();
    chk("rst1_vld", {7'd0, EX_ALU_VLD}, 8'd0);
    chk("rst1_ex", EX_ALU, 8'h00);
    RST = 1'b1;
    tick();
    chk("rst1_rel_vld", {7'd0, EX_ALU_VLD}, 8'd0);
    chk("rst1_rel_rdy", {7'd0, ALU_RDY}, 8'd1);

`ifdef ALU_MULT_EN
    drive(4'd2, 2'd0, 8'h0F, 8'h11, 8'h00, 8'h00);
    tick();
    // ADD presented for the whole busy window must be ignored.
    drive(4'd0, 2'd0, 8'h01, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_rdy_%0d", i), {7'd0, ALU_RDY}, 8'd0);
      chk($sformatf("mul_vld_%0d", i), {7'd0, EX_ALU_VLD}, 8'd0);
      tick();
    end
    ACT = 1'b0;
    chk("mul_done_vld", {7'd0, EX_ALU_VLD}, 8'd1);
    chk("mul_res", EX_ALU, 8'hFF);
    chk("mul_done_rdy", {7'd0, ALU_RDY}, 8'd1);
    tick();
    chk("mul_no_add", {7'd0, EX_ALU_VLD}, 8'd0);
    chk("mul_hold", EX_ALU, 8'hFF);

    // Reset three cycles into a multiply.
    drive(4'd2, 2'd0, 8'h07, 8'h05, 8'h00, 8'h00);
    tick();
    ACT = 1'b0;
    tick(); tick(); tick();
    RST = 1'b0;
    tick();
    chk("mrst_ex", EX_ALU, 8'h00);
    chk("mrst_vld", {7'd0, EX_ALU_VLD}, 8'd0);
    chk("mrst_rdy", {7'd0, ALU_RDY}, 8'd0);
    RST = 1'b1;
    tick();
    chk("mrst_rel_rdy", {7'd0, ALU_RDY}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("mrst_quiet_%0d", i), {7'd0, EX_ALU_VLD}, 8'd0);
      tick();
    end
`else
    run_op("pre_mul", 4'd0, 2'd0, 8'h50, 8'h05, 8'h55);
    drive(4'd2, 2'd0, 8'h02, 8'h03, 8'h00, 8'h00);
    tick();
    ACT = 1'b0;
    chk("mul0_rdy_a", {7'd0, ALU_RDY}, 8'd1);
    tick();
    chk("mul0_vld", {7'd0, EX_ALU_VLD}, 8'd1);
    chk("mul0_res", EX_ALU, 8'h00);
    chk("mul0_rdy_b", {7'd0, ALU_RDY}, 8'd1);
    // MULT immediately followed by ADD must stream back-to-back.
    drive(4'd2, 2'd0, 8'h02, 8'h03, 8'h00, 8'h00);
    tick();
    drive(4'd0, 2'd0, 8'h02, 8'h03, 8'h00, 8'h00);
    tick();
    ACT = 1'b0;
    chk("mul0_b2b_vld", {7'd0, EX_ALU_VLD}, 8'd1);
    chk("mul0_b2b_res", EX_ALU, 8'h00);
    tick();
    chk("add_b2b_vld", {7'd0, EX_ALU_VLD}, 8'd1);
    chk("add_b2b_res", EX_ALU, 8'h05);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
